// File: rtl/line_rasterizer.sv
// Bresenham line rasteriser: one segment per request/ready handshake, one pixel per clock.
// Define HIDDEN_DASH_EN to draw dontShow segments dashed instead of skipping them.
module line_rasterizer #(
  parameter int COLOR_CHANNEL_DEPTH = 2,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               request,
  input  logic [9:0]                         x0,
  input  logic [9:0]                         y0,
  input  logic [9:0]                         x1,
  input  logic [9:0]                         y1,
  input  logic [3*COLOR_CHANNEL_DEPTH-1:0]   color,
  input  logic                               dontShow,
  output logic                               ready,
  output logic [7:0]                         x_pix,
  output logic [6:0]                         y_pix,
  output logic [3*COLOR_CHANNEL_DEPTH-1:0]   color_out,
  output logic                               writeEn
);

  localparam int CW = 3 * COLOR_CHANNEL_DEPTH;
  localparam logic signed [10:0] W_LIM = 11'(SCREEN_W);
  localparam logic signed [10:0] H_LIM = 11'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t             state_reg;
  logic [9:0]         x0_reg, y0_reg, x1_reg, y1_reg;
  logic [CW-1:0]      color_reg;
  logic               hide_reg;
  logic signed [10:0] x_reg, y_reg;
  logic signed [11:0] dx_reg, dy_reg, err_reg;
  logic               sx_neg_reg, sy_neg_reg;

  logic signed [11:0] dx_diff, dy_diff, dx_abs, dy_abs, err_next;
  logic signed [12:0] e2;
  logic signed [10:0] x_next, y_next;
  logic               step_x, step_y, visible, at_end, pix_en, skip;

  always_comb begin
    dx_diff  = {{2{x1_reg[9]}}, x1_reg} - {{2{x0_reg[9]}}, x0_reg};
    dy_diff  = {{2{y1_reg[9]}}, y1_reg} - {{2{y0_reg[9]}}, y0_reg};
    dx_abs   = dx_diff[11] ? -dx_diff : dx_diff;
    dy_abs   = dy_diff[11] ? -dy_diff : dy_diff;
    e2       = {err_reg, 1'b0};
    // Both decisions look at the pre-update error term.
    step_x   = e2 >= $signed({dy_reg[11], dy_reg});
    step_y   = e2 <= $signed({dx_reg[11], dx_reg});
    err_next = err_reg + (step_x ? dy_reg : 12'sd0) + (step_y ? dx_reg : 12'sd0);
    x_next   = sx_neg_reg ? x_reg - 11'sd1 : x_reg + 11'sd1;
    y_next   = sy_neg_reg ? y_reg - 11'sd1 : y_reg + 11'sd1;
    visible  = !x_reg[10] && !y_reg[10] && (x_reg < W_LIM) && (y_reg < H_LIM);
    at_end   = (x_reg == {x1_reg[9], x1_reg}) && (y_reg == {y1_reg[9], y1_reg});
  end

`ifdef HIDDEN_DASH_EN
  logic step_odd_reg;
  assign skip   = 1'b0;
  assign pix_en = visible && !(hide_reg && step_odd_reg);
`else
  assign skip   = hide_reg;
  assign pix_en = visible;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      x0_reg     <= '0;
      y0_reg     <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      color_reg  <= '0;
      hide_reg   <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      err_reg    <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
      ready      <= 1'b0;
      x_pix      <= '0;
      y_pix      <= '0;
      color_out  <= '0;
      writeEn    <= 1'b0;
`ifdef HIDDEN_DASH_EN
      step_odd_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          writeEn <= 1'b0;
          if (request) begin
            x0_reg    <= x0;
            y0_reg    <= y0;
            x1_reg    <= x1;
            y1_reg    <= y1;
            color_reg <= color;
            hide_reg  <= dontShow;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (skip) begin
            ready     <= 1'b1;
            state_reg <= DONE;
          end else begin
            dx_reg     <= dx_abs;
            dy_reg     <= -dy_abs;
            err_reg    <= dx_abs - dy_abs;
            sx_neg_reg <= !(dx_diff > 12'sd0);
            sy_neg_reg <= !(dy_diff > 12'sd0);
            x_reg      <= {x0_reg[9], x0_reg};
            y_reg      <= {y0_reg[9], y0_reg};
            state_reg  <= DRAW;
`ifdef HIDDEN_DASH_EN
            step_odd_reg <= 1'b0;
`endif
          end
        end
        DRAW: begin
          x_pix     <= x_reg[7:0];
          y_pix     <= y_reg[6:0];
          color_out <= color_reg;
          writeEn   <= pix_en;
`ifdef HIDDEN_DASH_EN
          step_odd_reg <= !step_odd_reg;
`endif
          if (at_end) begin
            ready     <= 1'b1;
            state_reg <= DONE;
          end else begin
            if (step_x) x_reg <= x_next;
            if (step_y) y_reg <= y_next;
            err_reg <= err_next;
          end
        end
        DONE: begin
          writeEn <= 1'b0;
          if (!request) begin
            ready     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Responder end of the segment request/ready handshake used by the wireframe line sequencer. It accepts one 2D segment at a time: endpoints, colour and hidden flag. It rasterises the segment with integer Bresenham stepping at one pixel per clock and drives the VGA framebuffer write port. It asserts `ready` when the segment is finished, and only then will the sequencer present the next segment.

## Interface
Parameters:
- `COLOR_CHANNEL_DEPTH`, default 2: bits per RGB channel; colour width is 3*depth.
- `SCREEN_W`, default 160: visible width; pixels with x ≥ SCREEN_W are not written.
- `SCREEN_H`, default 120: visible height; pixels with y ≥ SCREEN_H are not written.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `request` in 1: segment valid; held high by the sequencer until `ready` is seen.
- `x0`, `y0`, `x1`, `y1` in 10 each: endpoints, two's complement, start (x0,y0) to end (x1,y1).
- `color` in 3*COLOR_CHANNEL_DEPTH: segment colour.
- `dontShow` in 1: hidden-edge flag for the segment.
- `ready` out 1: segment complete; held until `request` is low.
- `x_pix` out 8: pixel x, low 8 bits of current x.
- `y_pix` out 7: pixel y, low 7 bits of current y.
- `color_out` out 3*COLOR_CHANNEL_DEPTH: pixel colour.
- `writeEn` out 1: framebuffer write strobe, one pixel per high cycle.

## Operation
- **Reset:** all outputs are 0; state is IDLE; internal registers are cleared. Reset mid-segment aborts the line immediately, with no further writes.
- **IDLE:** when `request` is 1, latch `x0`, `y0`, `x1`, `y1`, `color` and `dontShow`, then go to LOAD. Inputs are not sampled again until the next IDLE.
- **LOAD:**
  - If the latched `dontShow` is 1 and HIDDEN_DASH_EN is undefined: go to DONE and set `ready` to 1.
  - Otherwise initialise the stepping registers and go to DRAW:
    - dx = |x1−x0|, dy = −|y1−y0|, both 12-bit signed.
    - sx = +1 if x1 > x0, else −1; sy likewise.
    - err = dx+dy, 12-bit signed.
    - Set x = x0 and y = y0.
- **DRAW, every cycle:**
  - Register `x_pix`, `y_pix` and `color_out` from (x, y, colour).
  - Set `writeEn` = visible, where visible = x ≥ 0, y ≥ 0, x < SCREEN_W and y < SCREEN_H (signed compare).
  - If (x,y) == (x1,y1): go to DONE and set `ready` to 1.
  - Otherwise compute e2 = 2·err:
    - if e2 ≥ dy: err += dy, x += sx;
    - if e2 ≤ dx: err += dx, y += sy.
    - Both updates may apply in the same cycle and use the old err.
- **Pixel count:** max(dx, −dy)+1. A degenerate segment with start equal to end emits exactly one pixel. Off-screen pixels still consume a cycle, with `writeEn` 0.
- **DONE:**
  - `writeEn` is 0.
  - `ready` stays 1 while `request` is 1.
  - When `request` is 0, set `ready` to 0 and go to IDLE.
  - A new request cannot be accepted in the same cycle that `ready` falls; the earliest acceptance is the following cycle.
- **Request dropped early:** if `request` falls during LOAD or DRAW, it is ignored and the segment completes. In that case `ready` is high for exactly one cycle in DONE.
- **Arithmetic widths:** coordinates are 10-bit signed and step registers are 11-bit signed. This covers the full −512..511 span without wrap; err and e2 are 12/13-bit signed.

## Timing
- Let edge 0 be the edge at which IDLE sees `request`=1.
- LOAD executes at edge 1.
- The first pixel is registered at edge 2.
- For an N-pixel segment, `writeEn` (for visible pixels) is high in the N cycles following edges 2..N+1.
- `ready` rises at edge N+1, coincident with the final pixel.
- For a skipped hidden segment, `ready` rises at edge 1 with no writes.
- `ready` falls one edge after `request` is sampled low.
- Throughput: one pixel per clock, plus 3 cycles per segment of overhead, not counting handshake return.

## Configuration
- **`HIDDEN_DASH_EN` defined:** a `dontShow` segment is drawn dashed. Pixels with an odd step index (counting from 0 at the start point) have `writeEn` forced to 0; the cycle count is unchanged.
- **`HIDDEN_DASH_EN` undefined:** a `dontShow` segment is skipped entirely, as described under LOAD.

## Test plan
- **Horizontal line:** (0,0)→(3,0), `color`=6'b111111 → four writes at (0,0), (1,0), (2,0), (3,0), colour 6'b111111. `ready` rises with the 4th write; `ready` falls 1 cycle after `request` drops.
- **Point segment:** (5,5)→(5,5) → exactly one write at (5,5); `ready` at edge 2.
- **Reverse diagonal and shallow slope:**
  - (3,3)→(0,0) → writes at (3,3), (2,2), (1,1), (0,0).
  - (0,0)→(4,2) → writes at (0,0), (1,0) or (1,1) per the stated stepping, ending at (4,2) with 5 writes.
- **Clipping:** (10'h3FE,1)→(1,1), i.e. x from −2 → 4 DRAW cycles, `writeEn` high only for x=0 and x=1; (158,0)→(161,0) → writes only at x=158 and 159.
- **Hidden segment:** `dontShow`=1, (0,0)→(7,0):
  - macro undefined → zero writes, `ready` at edge 1;
  - macro defined → writes at x=0, 2, 4, 6 over 8 DRAW cycles.
- **Reset and handshake abuse:**
  - `resetn` pulsed low during DRAW → all outputs 0 asynchronously, IDLE afterwards, with a fresh request accepted normally.
  - `request` dropped at edge 1 → line completes, `ready` high for exactly 1 cycle.
